// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Holds the PC, fetches 32-bit MIPS instructions over a req/ack handshake, buffers them in a
//   small FIFO and presents the head entry, split into R/I fields, to decode with valid/ready.
//   A taken branch flushes the FIFO, reloads the PC and drops any stale in-flight response.
//
// Parameters
//   RESET_PC   : PC loaded on reset (word-aligned)
//   FIFO_DEPTH : instruction buffer entries (>= 1, power of two)
//
// Ports
//   clk, reset                  : clock, asynchronous active-high reset
//   imem_req/imem_addr          : fetch request and address (address stable while req is high)
//   imem_ack/imem_rdata         : response strobe and instruction word (same cycle)
//   branch_taken/branch_target  : one-cycle redirect pulse and new PC
//   dec_valid/dec_ready         : head-entry handshake with decode
//   opcode, func, rs, rt, rd, shamt, imm : fields of the head word (0 while dec_valid=0)
//   dec_pc                      : address of the head instruction
//   stall_cycles                : only with IFU_PERF_CNT_EN defined; saturating count of
//                                 cycles with dec_ready=1 and dec_valid=0
//
// Optional feature macro: IFU_PERF_CNT_EN

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm,
   output logic [31:0] dec_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StWaitAck, StDiscard} state_e;

   state_e          state_q;
   logic [31:0]     pc_q;
   logic [63:0]     mem_q [FIFO_DEPTH];  // {pc, instruction}
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic            push;
   logic            pop;
   logic [63:0]     head_word;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   // A redirect in the ack cycle drops the word, so it never reaches the FIFO.
   assign push = (state_q == StWaitAck) && imem_ack && !branch_taken;
   assign pop  = dec_valid && dec_ready;

   // ---------------------------------------------------------------------------------------
   // Fetch FSM: owns PC, request and address
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         pc_q      <= RESET_PC;
      end else begin
         case (state_q)
            StIdle: begin
               if (branch_taken) begin
                  pc_q <= branch_target;
               end else if (count_q < DepthCnt) begin
                  // Only issue while there is room, so the FIFO can never overflow.
                  imem_req  <= 1'b1;
                  imem_addr <= pc_q;
                  state_q   <= StWaitAck;
               end
            end
            StWaitAck: begin
               if (branch_taken) begin
                  pc_q <= branch_target;
                  if (imem_ack) begin
                     imem_req <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     // Keep the old request alive until memory answers, then drop it.
                     state_q <= StDiscard;
                  end
               end else if (imem_ack) begin
                  pc_q     <= pc_q + 32'd4;
                  imem_req <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StDiscard: begin
               if (branch_taken) begin
                  pc_q <= branch_target;
               end
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state_q  <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Instruction FIFO
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (branch_taken) begin
         // Flush wins over any same-cycle push or pop.
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: contents are only visible when dec_valid is high.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {pc_q, imem_rdata};
      end
   end

   // ---------------------------------------------------------------------------------------
   // Decode-side outputs: slices of the registered head entry, forced to 0 when empty
   // ---------------------------------------------------------------------------------------
   assign dec_valid = (count_q != '0);
   assign head_word = dec_valid ? mem_q[rd_ptr_q] : 64'd0;

   assign dec_pc = head_word[63:32];
   assign opcode = head_word[31:26];
   assign rs     = head_word[25:21];
   assign rt     = head_word[20:16];
   assign rd     = head_word[15:11];
   assign shamt  = head_word[10:6];
   assign func   = head_word[5:0];
   assign imm    = head_word[15:0];

`ifdef IFU_PERF_CNT_EN
   // Counts decode starvation; survives redirects and saturates instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= 32'd0;
      end else if (dec_ready && !dec_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by random traffic, all checked
// against a transaction-level model (outstanding request + queue of {pc, word}).

module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] dec_pc;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .opcode        (opcode),
      .func          (func),
      .rs            (rs),
      .rt            (rt),
      .rd            (rd),
      .shamt         (shamt),
      .imm           (imm),
      .dec_pc        (dec_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_pend;
   bit          m_stale;
   logic [31:0] m_addr;
   logic [63:0] m_q [$];
   logic [31:0] m_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_pend  = 1'b0;
      m_stale = 1'b0;
      m_addr  = RESET_PC;
      m_q.delete();
      m_stall = 32'd0;
   endtask

   // One clock of architectural behaviour, computed from the start-of-cycle state.
   task automatic model_step(input bit ack, input bit br, input bit rdy,
                             input logic [31:0] tgt, input logic [31:0] data);
      int size0;
      size0 = m_q.size();
      if (rdy && size0 == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (br) begin
         m_q.delete();
         m_pc = tgt;
         if (m_pend) begin
            if (ack) begin
               m_pend  = 1'b0;
               m_stale = 1'b0;
            end else begin
               m_stale = 1'b1;
            end
         end
      end else begin
         if (rdy && size0 > 0) void'(m_q.pop_front());
         if (m_pend) begin
            if (ack) begin
               if (!m_stale) begin
                  m_q.push_back({m_pc, data});
                  m_pc = m_pc + 32'd4;
               end
               m_pend  = 1'b0;
               m_stale = 1'b0;
            end
         end else if (size0 < int'(DEPTH)) begin
            m_pend  = 1'b1;
            m_addr  = m_pc;
            m_stale = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 64'd0;
      chk("imem_req", imem_req, m_pend);
      if (m_pend) chk("imem_addr", imem_addr, m_addr);
      chk("dec_valid", dec_valid, m_q.size() > 0);
      chk("dec_pc", dec_pc, head[63:32]);
      chk("opcode", opcode, head[31:26]);
      chk("rs", rs, head[25:21]);
      chk("rt", rt, head[20:16]);
      chk("rd", rd, head[15:11]);
      chk("shamt", shamt, head[10:6]);
      chk("func", func, head[5:0]);
      chk("imm", imm, head[15:0]);
`ifdef IFU_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
   endtask

   // Drive inputs at a falling edge, let one rising edge pass, then check at the next fall.
   task automatic step(input bit ack, input bit br, input bit rdy,
                       input logic [31:0] tgt, input logic [31:0] data);
      imem_ack      = ack;
      branch_taken  = br;
      dec_ready     = rdy;
      branch_target = tgt;
      imem_rdata    = data;
      model_step(ack, br, rdy, tgt, data);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      imem_ack     = 1'b0;
      branch_taken = 1'b0;
      dec_ready    = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      chk("rst_addr", imem_addr, RESET_PC);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();

      // Reset, then first two instructions
      do_reset();
      step(0, 0, 0, '0, $urandom);
      chk("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'h0);
      step(1, 0, 0, '0, 32'h0022_1820);
      chk("t1_valid", dec_valid, 1'b1);
      chk("t1_opcode", opcode, 6'h00);
      chk("t1_func", func, 6'h20);
      chk("t1_rs", rs, 5'd1);
      chk("t1_rt", rt, 5'd2);
      chk("t1_rd", rd, 5'd3);
      chk("t1_shamt", shamt, 5'd0);
      chk("t1_pc", dec_pc, 32'h0);
      step(0, 0, 0, '0, $urandom);
      chk("t2_addr", imem_addr, 32'h4);
      step(1, 0, 1, '0, 32'h8E08_0004);
      chk("t2_opcode", opcode, 6'h23);
      chk("t2_rs", rs, 5'd16);
      chk("t2_rt", rt, 5'd8);
      chk("t2_imm", imm, 16'h0004);
      chk("t2_pc", dec_pc, 32'h4);

      // Fill with decode stalled, then drain in order
      do_reset();
      for (int i = 0; i < 8; i++) step(m_pend, 0, 0, '0, $urandom);
      chk("fill_req_low", imem_req, 1'b0);
      chk("fill_valid", dec_valid, 1'b1);
      chk("fill_head0", dec_pc, 32'h0);
      step(0, 0, 1, '0, $urandom);
      chk("drain_head1", dec_pc, 32'h4);
      step(0, 0, 1, '0, $urandom);
      chk("drain_empty", dec_valid, 1'b0);
      chk("pend8_addr", imem_addr, 32'h8);

      // Redirect while the fetch of 0x8 is outstanding
      step(0, 1, 0, 32'h40, $urandom);
      chk("br_valid", dec_valid, 1'b0);
      chk("br_req_held", imem_req, 1'b1);
      chk("br_addr_held", imem_addr, 32'h8);
      step(1, 0, 0, '0, $urandom);
      chk("discard_valid", dec_valid, 1'b0);
      chk("discard_req", imem_req, 1'b0);
      step(0, 0, 0, '0, $urandom);
      chk("redir_addr", imem_addr, 32'h40);
      step(1, 0, 0, '0, $urandom);
      chk("redir_pc", dec_pc, 32'h40);

      // Redirect coincident with ack and dec_ready
      step(0, 0, 0, '0, $urandom);
      step(1, 1, 1, 32'h100, $urandom);
      chk("coinc_valid", dec_valid, 1'b0);
      chk("coinc_req", imem_req, 1'b0);
      step(0, 0, 0, '0, $urandom);
      chk("coinc_addr", imem_addr, 32'h100);

      // Asynchronous reset in the middle of a pending fetch
      step(1, 0, 0, '0, $urandom);
      step(0, 0, 0, '0, $urandom);
      chk("pre_rst_req", imem_req, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("arst_req", imem_req, 1'b0);
      chk("arst_addr", imem_addr, RESET_PC);
      chk("arst_valid", dec_valid, 1'b0);
`ifdef IFU_PERF_CNT_EN
      chk("arst_stall", stall_cycles, 32'd0);
`endif
      do_reset();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         bit ack;
         bit br;
         bit rdy;
         logic [31:0] tgt;
         ack = m_pend && ($urandom_range(0, 1) == 1);
         br  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
         step(ack, br, rdy, tgt, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
